// File: rtl/caliptra_ss_tb_svc_dispatch_pkg.sv
// Shared types for the TB service command dispatcher: opcodes, special operands, FSM states.
package caliptra_ss_tb_svc_pkg;

  typedef enum logic [1:0] {
    OP_SET     = 2'b00,
    OP_CLR     = 2'b01,
    OP_PULSE   = 2'b10,
    OP_SPECIAL = 2'b11
  } tb_svc_op_e;

  localparam logic [5:0] TB_SVC_CLR_ALL = 6'h3F;
  localparam logic [5:0] TB_SVC_CLR_ERR = 6'h3E;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } tb_svc_state_e;

endpackage

// File: rtl/caliptra_ss_tb_svc_dispatch_if.sv
// Firmware command mailbox: one-cycle strobe plus command byte.
interface caliptra_ss_tb_svc_dispatch_if;
  logic       tb_service_cmd_valid;
  logic [7:0] tb_service_cmd;

  modport master (output tb_service_cmd_valid, output tb_service_cmd);
  modport slave  (input  tb_service_cmd_valid, input  tb_service_cmd);
endinterface

// File: rtl/caliptra_ss_tb_svc_dispatch_fifo.sv
// Byte command FIFO; a write while full is still accepted when the head is popped that cycle.
module caliptra_ss_tb_svc_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wdata,
  input  logic        rd_en,
  output logic [7:0]  rdata,
  output logic        empty,
  output logic        drop,
  output logic [AW:0] level
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);
  assign drop  = wr_en && !push;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/caliptra_ss_tb_svc_dispatch.sv
// Decodes queued firmware command bytes into per-channel override enables (set/clear/timed pulse).
module caliptra_ss_tb_svc_dispatch
  import caliptra_ss_tb_svc_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PULSE  = 16,
  parameter int LEN_SHIFT  = 2,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 cptra_rst_b,
  caliptra_ss_tb_svc_dispatch_if.slave cmd,
  output logic [NUM_CH-1:0]    ovr_en_o,
  output logic                 busy_o,
  output logic                 overflow_o,
  output logic                 bad_cmd_o,
  output logic [LVL_W-1:0]     fifo_level_o
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  tb_svc_state_e    state_q;
  logic [CNT_W-1:0] cnt_q, pulse_len_q, len_calc;
  logic [CH_W-1:0]  pch_q, ch;
  logic [7:0]       head;
  logic [5:0]       opd;
  tb_svc_op_e       op;
  logic             empty, drop, pop, ch_ok;

  // The last pulse cycle may already pop, so the next command lands as the channel falls.
  assign pop = !empty && ((state_q == IDLE) || (cnt_q == CNT_W'(1)));

  caliptra_ss_tb_svc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (cptra_rst_b),
    .wr_en (cmd.tb_service_cmd_valid),
    .wdata (cmd.tb_service_cmd),
    .rd_en (pop),
    .rdata (head),
    .empty (empty),
    .drop  (drop),
    .level (fifo_level_o)
  );

  assign op       = tb_svc_op_e'(head[7:6]);
  assign opd      = head[5:0];
  assign ch       = opd[CH_W-1:0];
  assign ch_ok    = (32'(opd) < NUM_CH);
  assign len_calc = CNT_W'((32'(opd) + 32'd1) << LEN_SHIFT);
  assign busy_o   = (state_q != IDLE) || !empty;

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pch_q       <= '0;
      pulse_len_q <= CNT_W'(DEF_PULSE);
      ovr_en_o    <= '0;
      overflow_o  <= 1'b0;
      bad_cmd_o   <= 1'b0;
    end else begin
      if (state_q == PULSE) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          ovr_en_o[pch_q] <= 1'b0;
          state_q         <= IDLE;
        end
      end
      // A command popped on the final pulse cycle is applied after the fall, so it wins.
      if (pop) begin
        case (op)
          OP_SET:   if (ch_ok) ovr_en_o[ch] <= 1'b1; else bad_cmd_o <= 1'b1;
          OP_CLR:   if (ch_ok) ovr_en_o[ch] <= 1'b0; else bad_cmd_o <= 1'b1;
          OP_PULSE: begin
            if (ch_ok) begin
              ovr_en_o[ch] <= 1'b1;
              pch_q        <= ch;
              cnt_q        <= pulse_len_q;
              state_q      <= PULSE;
            end else begin
              bad_cmd_o <= 1'b1;
            end
          end
          OP_SPECIAL: begin
            if (opd == TB_SVC_CLR_ALL) begin
              ovr_en_o <= '0;
            end else if (opd == TB_SVC_CLR_ERR) begin
              overflow_o <= 1'b0;
              bad_cmd_o  <= 1'b0;
            end else begin
              pulse_len_q <= (len_calc == '0) ? CNT_W'(1) : len_calc;
            end
          end
          default: ;
        endcase
      end
      if (drop) overflow_o <= 1'b1;
    end
  end
endmodule
